// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle for uart_tx_arbiter.
// master = arbiter view, slave = requesters plus transmitter view.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int IDW        = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic [DATA_WIDTH-1:0]         tx_data;
    logic                          tx_valid;
    logic                          tx_ready;
    logic                          tx_done;
    logic [IDW-1:0]                grant_id;
    logic                          busy;

    modport master (
        input  req_valid, req_data, tx_ready, tx_done,
        output req_ready, tx_data, tx_valid, grant_id, busy
    );

    modport slave (
        output req_valid, req_data, tx_ready, tx_done,
        input  req_ready, tx_data, tx_valid, grant_id, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter, one frame per grant.
// Define UART_TX_ARB_BURST_EN to let a requester keep the line for up to MAX_BURST frames.
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    parameter int IDW        = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_tx_arbiter_if.master  bus
);
    // state       | meaning
    // S_IDLE      | line free, arbitrate when transmitter is ready
    // S_LAUNCH    | tx_valid high until transmitter drops tx_ready
    // S_WAIT_DONE | frame in flight, wait for tx_done
    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT_DONE} state_t;

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("uart_tx_arbiter: NUM_REQ must be 2..8");
    end
    if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_max_burst
        $error("uart_tx_arbiter: MAX_BURST must be 1..15");
    end

    state_t                state_q, state_d;
    logic [NUM_REQ-1:0]    req_ready_q, req_ready_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  busy_q, busy_d;
    logic [IDW-1:0]        grant_q, grant_d;
    logic [IDW-1:0]        last_q, last_d;
    logic [IDW-1:0]        cand, rr_win, win;
    logic                  rr_found;
`ifdef UART_TX_ARB_BURST_EN
    logic [3:0]            burst_q, burst_d;
    logic                  keep;
`endif

    always_comb begin
        rr_found = 1'b0;
        rr_win   = '0;
        cand     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDW'((int'(last_q) + k) % NUM_REQ);
            if (!rr_found && bus.req_valid[cand]) begin
                rr_found = 1'b1;
                rr_win   = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready_d = '0;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        busy_d      = busy_q;
        grant_d     = grant_q;
        last_d      = last_q;
        win         = rr_win;
`ifdef UART_TX_ARB_BURST_EN
        burst_d     = burst_q;
        // last_q differs from grant_q only straight after reset, so the first grant is never a repeat
        keep        = (last_q == grant_q) && bus.req_valid[grant_q] &&
                      (burst_q < 4'(MAX_BURST - 1));
        if (keep) win = grant_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.tx_ready && rr_found) begin
                    state_d          = S_LAUNCH;
                    req_ready_d[win] = 1'b1;
                    tx_data_d        = bus.req_data[win*DATA_WIDTH +: DATA_WIDTH];
                    tx_valid_d       = 1'b1;
                    busy_d           = 1'b1;
                    grant_d          = win;
`ifdef UART_TX_ARB_BURST_EN
                    burst_d          = keep ? burst_q + 4'd1 : 4'd0;
`endif
                end
            end
            S_LAUNCH: begin
                if (!bus.tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (bus.tx_done) begin
                    last_d  = grant_q;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            req_ready_q <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            grant_q     <= '0;
            last_q      <= IDW'(NUM_REQ - 1);
`ifdef UART_TX_ARB_BURST_EN
            burst_q     <= 4'd0;
`endif
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            busy_q      <= busy_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
`ifdef UART_TX_ARB_BURST_EN
            burst_q     <= burst_d;
`endif
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.busy      = busy_q;
    assign bus.grant_id  = grant_q;
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one `uart_tx` transmitter between `NUM_REQ` byte-stream requesters, for example a debug console, a status reporter and a loopback echo. Winners are chosen round-robin and granted for exactly one frame each. The block sits between the requesters and the `tx_data`/`tx_valid`/`tx_ready`/`tx_done` side of `uart_top`. It hands off one byte to the transmitter and holds off all other requesters until that frame's `tx_done` pulse.

## Interface
- `NUM_REQ`, 4: number of requesters, range 2..8.
- `DATA_WIDTH`, 8: byte width; must match the transmitter.
- `MAX_BURST`, 4: bytes one requester may send back-to-back when bursting is compiled in; range 1..15.
- `IDW`, `$clog2(NUM_REQ)`: derived width of `grant_id`.
- `clk`  in  1  single clock domain, shared with the transmitter.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  `NUM_REQ`  requester i has a byte pending; held until accepted.
- `req_data`  in  `NUM_REQ*DATA_WIDTH`  requester i's byte in slice `[i*DATA_WIDTH +: DATA_WIDTH]`; stable while `req_valid[i]` is high.
- `req_ready`  out  `NUM_REQ`  one-hot, one-cycle accept pulse; the byte transfers when `req_valid[i] & req_ready[i]`.
- `tx_data`  out  `DATA_WIDTH`  registered byte to the transmitter.
- `tx_valid`  out  1  launch request to the transmitter.
- `tx_ready`  in  1  transmitter idle.
- `tx_done`  in  1  one-cycle end-of-frame pulse from the transmitter.
- `grant_id`  out  `IDW`  index of the requester currently owning the line.
- `busy`  out  1  a frame is launched or in flight.

## Operation
- FSM states and transitions:
  - IDLE: if `tx_ready` is high and any `req_valid` is high, select winner w, go to LAUNCH. Otherwise stay.
  - LAUNCH: hold `tx_valid`=1 until a cycle with `tx_ready`=0 is observed. Then drive `tx_valid`=0 and go to WAIT_DONE.
  - WAIT_DONE: on `tx_done`, set `last` to `grant_id` and go to IDLE.
- Winner selection: the first i with `req_valid[i]` set, searching from `last+1` upward modulo `NUM_REQ`.
- Pointer reset: `last` resets to `NUM_REQ-1`, so requester 0 has first priority after reset.
- On selection, registered on the same edge:
  - `tx_data` ← `req_data[w]`.
  - `tx_valid` ← 1.
  - `req_ready[w]` ← 1 for exactly one cycle.
  - `grant_id` ← w.
  - `busy` ← 1.
- `busy` clears on the edge after `tx_done`.
- `tx_data` and `grant_id` hold their values until the next selection.
- Request withdrawal: a requester that drops `req_valid` before its accept pulse simply loses that slot; no error is raised.
- Requests arriving during LAUNCH or WAIT_DONE wait; they are arbitrated in IDLE only.
- `tx_done` received outside WAIT_DONE is ignored.
- Reset mid-frame: all state returns to IDLE asynchronously and `tx_valid` drops immediately. The transmitter shares `rst_n`, so no partial frame is resumed. A byte already accepted is lost; its requester is not re-notified.

## Timing
- Reset values: `req_ready`=0, `tx_data`=0, `tx_valid`=0, `grant_id`=0, `busy`=0, `last`=`NUM_REQ-1`, state IDLE.
- Latency from `req_valid` rising (with the FSM in IDLE and `tx_ready`=1) to `tx_valid`/`req_ready`: 1 clock.
- `tx_valid` stays high for at least one cycle. It falls on the edge after the first cycle in which `tx_ready`=0 is sampled.
- The transmitter re-asserts `tx_ready` one cycle after `tx_done`. The arbiter therefore cannot launch the next frame until 2 cycles after `tx_done`; this gap is required, not a defect.
- `req_ready` never asserts on more than one bit, and never asserts outside the IDLE→LAUNCH edge.

## Configuration
- Macro: `UART_TX_ARB_BURST_EN`.
- Defined:
  - A 4-bit `burst_cnt` counts consecutive grants to `grant_id`.
  - In IDLE, if `req_valid[grant_id]` is high and `burst_cnt < MAX_BURST-1`, the same requester wins again and `burst_cnt` increments.
  - Otherwise normal round-robin from `grant_id+1` applies and `burst_cnt` resets to 0.
  - `burst_cnt` resets to 0.
  - While the same requester keeps winning, `last` is not advanced.
- Undefined: strict round-robin per frame; `burst_cnt` and `MAX_BURST` have no effect.

## Test plan
- Single request: reset, `req_valid`=4'b0100, `req_data[2]`=8'hA5, `tx_ready`=1.
  - Next edge: `req_ready`=4'b0100, `tx_data`=8'hA5, `tx_valid`=1, `grant_id`=2, `busy`=1.
  - Exactly one frame is sent, then `busy`=0.
- Fairness, all four requesting continuously with bytes 8'h10/8'h21/8'h32/8'h43, macro off:
  - `tx_data` sequence is 10, 21, 32, 43, 10, …
  - `grant_id` sequence is 0, 1, 2, 3, 0.
- Burst, macro on, `MAX_BURST`=3, requesters 0 and 1 continuously valid: grants are 0, 0, 0, 1, 1, 1, 0.
- Busy hold-off: requester 3 raises `req_valid` during WAIT_DONE. It receives no `req_ready` until 2 cycles after `tx_done`, then is granted.
- Reset mid-frame: assert `rst_n`=0 during WAIT_DONE.
  - `tx_valid`, `busy` and `req_ready` are 0 immediately.
  - After release, requester 0 wins first.
- Withdrawal: requester 1 drops `req_valid` while requester 0's frame is in flight.
  - Requester 1 is skipped.
  - With requester 2 pending, `grant_id`=2 is next.
